// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller serving latched floor requests in SCAN order.
// Each floor step takes MOVE_CYCLES clocks and each stop keeps the door open
// for DOOR_CYCLES clocks (longer while door_hold is high or on a re-request).
//
// Request interface: req_valid is a strobe with no back-pressure. In every
// cycle where req_valid is high, req_floor is consumed at the rising edge.
// An out-of-range floor is dropped and flagged on req_err for one cycle.
module elevator_scan_ctrl #(
   parameter int NUM_FLOORS  = 8,
   parameter int FLOOR_W     = 3,
   parameter int MOVE_CYCLES = 3,
   parameter int DOOR_CYCLES = 4,
   parameter int RESET_FLOOR = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   input  logic                  door_hold,
   output logic [FLOOR_W-1:0]    floor,
   output logic [1:0]            direction,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  req_err,
   output logic [1:0]            dbg_state
);

   // move_cnt counts 0..MOVE_CYCLES-1, door_cnt counts DOOR_CYCLES..0
   localparam int MC_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam int DC_W = $clog2(DOOR_CYCLES + 1);

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   state_t                r_state;
   logic [FLOOR_W-1:0]    r_floor;
   logic                  r_last_up;
   logic [MC_W-1:0]       r_move_cnt;
   logic [DC_W-1:0]       r_door_cnt;
   logic [1:0]            r_direction;
   logic                  r_door_open;
   logic [NUM_FLOORS-1:0] r_pending;
   logic                  r_req_err;

   state_t                w_state_nxt;
   logic [FLOOR_W-1:0]    w_floor_nxt;
   logic                  w_last_up_nxt;
   logic [MC_W-1:0]       w_move_cnt_nxt;
   logic [DC_W-1:0]       w_door_cnt_nxt;
   logic [1:0]            w_dir_nxt;
   logic                  w_door_open_nxt;
   logic [NUM_FLOORS-1:0] w_set_mask;
   logic [NUM_FLOORS-1:0] w_clr_mask;

   logic                  w_req_ok;
   logic                  w_req_here;
   logic [NUM_FLOORS-1:0] w_req_mask;
   logic [NUM_FLOORS-1:0] w_floor_mask;
   logic [FLOOR_W-1:0]    w_step_floor;
   logic [NUM_FLOORS-1:0] w_step_mask;
   logic                  w_above;
   logic                  w_below;
   logic                  w_ahead;
   logic                  w_behind;
   logic                  w_move_done;
   logic                  w_door_last;

   // Request qualification and one-hot masks for the request, the current
   // floor and the floor the car reaches on its next step.
   assign w_req_ok     = req_valid && (int'(req_floor) < NUM_FLOORS);
   assign w_req_here   = w_req_ok && (req_floor == r_floor);
   assign w_req_mask   = w_req_ok ? (NUM_FLOORS'(1) << req_floor) : '0;
   assign w_floor_mask = NUM_FLOORS'(1) << r_floor;
   assign w_step_floor = r_last_up ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
   assign w_step_mask  = NUM_FLOORS'(1) << w_step_floor;
   assign w_move_done  = (r_move_cnt == MC_W'(MOVE_CYCLES - 1));
   assign w_door_last  = (r_door_cnt <= DC_W'(1));

   // Scan the pending vector for requests strictly above / below the car.
   always_comb begin
      w_above = 1'b0;
      w_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (r_pending[i]) begin
            if (i > int'(r_floor)) w_above = 1'b1;
            if (i < int'(r_floor)) w_below = 1'b1;
         end
      end
   end

   assign w_ahead  = r_last_up ? w_above : w_below;
   assign w_behind = r_last_up ? w_below : w_above;

   // Next-state and next-output decisions for the IDLE / MOVE / DOOR machine.
   always_comb begin
      w_state_nxt     = r_state;
      w_floor_nxt     = r_floor;
      w_last_up_nxt   = r_last_up;
      w_move_cnt_nxt  = r_move_cnt;
      w_door_cnt_nxt  = r_door_cnt;
      w_dir_nxt       = r_direction;
      w_door_open_nxt = r_door_open;
      w_set_mask      = w_req_mask;
      w_clr_mask      = '0;

      case (r_state)
         ST_IDLE: begin
            if (|(r_pending & w_floor_mask)) begin
               // Serve the floor the car is already at; direction stays idle.
               w_state_nxt     = ST_DOOR;
               w_door_cnt_nxt  = DC_W'(DOOR_CYCLES);
               w_door_open_nxt = 1'b1;
               w_clr_mask      = w_floor_mask;
            end else if (w_ahead) begin
               w_state_nxt    = ST_MOVE;
               w_move_cnt_nxt = '0;
               w_dir_nxt      = r_last_up ? DIR_UP : DIR_DOWN;
            end else if (w_behind) begin
               w_state_nxt    = ST_MOVE;
               w_move_cnt_nxt = '0;
               w_last_up_nxt  = ~r_last_up;
               w_dir_nxt      = r_last_up ? DIR_DOWN : DIR_UP;
            end
         end

         ST_MOVE: begin
            if (w_move_done) begin
               w_floor_nxt    = w_step_floor;
               w_move_cnt_nxt = '0;
               // A request landing on the arrival edge is served by this stop.
               if (|((r_pending | w_req_mask) & w_step_mask)) begin
                  w_state_nxt     = ST_DOOR;
                  w_door_cnt_nxt  = DC_W'(DOOR_CYCLES);
                  w_door_open_nxt = 1'b1;
                  w_clr_mask      = w_step_mask;
               end
            end else begin
               w_move_cnt_nxt = r_move_cnt + MC_W'(1);
            end
         end

         ST_DOOR: begin
            if (w_req_here) begin
               // Re-request at the open door restarts the dwell instead of queueing.
               w_set_mask     = '0;
               w_door_cnt_nxt = DC_W'(DOOR_CYCLES);
            end else if (!door_hold) begin
               if (w_door_last) begin
                  w_door_cnt_nxt  = '0;
                  w_door_open_nxt = 1'b0;
                  if (w_ahead) begin
                     w_state_nxt    = ST_MOVE;
                     w_move_cnt_nxt = '0;
                     w_dir_nxt      = r_last_up ? DIR_UP : DIR_DOWN;
                  end else if (w_behind) begin
                     w_state_nxt    = ST_MOVE;
                     w_move_cnt_nxt = '0;
                     w_last_up_nxt  = ~r_last_up;
                     w_dir_nxt      = r_last_up ? DIR_DOWN : DIR_UP;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_dir_nxt   = DIR_IDLE;
                  end
               end else begin
                  w_door_cnt_nxt = r_door_cnt - DC_W'(1);
               end
            end
         end

         default: begin
            w_state_nxt     = ST_IDLE;
            w_dir_nxt       = DIR_IDLE;
            w_door_open_nxt = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Car position, counters, registered outputs and the request bitmap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_floor     <= FLOOR_W'(RESET_FLOOR);
         r_last_up   <= 1'b1;
         r_move_cnt  <= '0;
         r_door_cnt  <= '0;
         r_direction <= DIR_IDLE;
         r_door_open <= 1'b0;
         r_pending   <= '0;
         r_req_err   <= 1'b0;
      end else begin
         r_floor     <= w_floor_nxt;
         r_last_up   <= w_last_up_nxt;
         r_move_cnt  <= w_move_cnt_nxt;
         r_door_cnt  <= w_door_cnt_nxt;
         r_direction <= w_dir_nxt;
         r_door_open <= w_door_open_nxt;
         // Clear beats set when both hit the same floor on one edge.
         r_pending   <= (r_pending | w_set_mask) & ~w_clr_mask;
         r_req_err   <= req_valid && !w_req_ok;
      end
   end

   assign floor     = r_floor;
   assign direction = r_direction;
   assign door_open = r_door_open;
   assign pending   = r_pending;
   assign req_err   = r_req_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl: an 8-floor instance checked every
// cycle against a behavioural model plus directed scenarios, and a 6-floor
// instance for out-of-range requests and top-floor behaviour.
module tb_elevator_scan_ctrl;
   localparam int NF = 8;
   localparam int MC = 3;
   localparam int DC = 4;
   localparam int M_IDLE   = 0;
   localparam int M_TRAVEL = 1;
   localparam int M_DOOR   = 2;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 8-floor instance
   logic       req_valid;
   logic [2:0] req_floor;
   logic       door_hold;
   logic [2:0] floor;
   logic [1:0] direction;
   logic       door_open;
   logic [7:0] pending;
   logic       req_err;
   logic [1:0] dbg_state;

   // 6-floor instance
   logic       req6_valid;
   logic [2:0] req6_floor;
   logic       hold6;
   logic [2:0] floor6;
   logic [1:0] direction6;
   logic       door_open6;
   logic [5:0] pending6;
   logic       req_err6;
   logic [1:0] dbg_state6;

   elevator_scan_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
      .door_hold(door_hold), .floor(floor), .direction(direction),
      .door_open(door_open), .pending(pending), .req_err(req_err),
      .dbg_state(dbg_state)
   );

   elevator_scan_ctrl #(.NUM_FLOORS(6), .FLOOR_W(3)) dut6 (
      .clk(clk), .rst(rst), .req_valid(req6_valid), .req_floor(req6_floor),
      .door_hold(hold6), .floor(floor6), .direction(direction6),
      .door_open(door_open6), .pending(pending6), .req_err(req_err6),
      .dbg_state(dbg_state6)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: expected stop order and observed stops / door episode lengths
   logic [2:0] exp_q[$];
   logic [2:0] stop_q[$];
   int         door_len_q[$];
   int         phase = 0;
   int         floor4_open = 0;
   int         pend_while_open = 0;
   int         floor6_max = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (8 floors) ----------------
   int         m_floor;
   bit [NF-1:0] m_pend;
   int         m_mode;
   bit         m_up;
   int         m_travel;
   int         m_doorl;
   logic [1:0] m_dir;
   bit         m_err;
   bit         m_live = 1'b0;
   bit         m_ok;
   bit         m_go;
   bit [NF-1:0] m_set;
   bit [NF-1:0] m_clr;

   function automatic bit side_has(input bit [NF-1:0] p, input int fl, input bit up);
      for (int i = 0; i < NF; i++) begin
         if (p[i] && (up ? (i > fl) : (i < fl))) return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_floor = 0; m_pend = '0; m_mode = M_IDLE; m_up = 1'b1;
         m_travel = 0; m_doorl = 0; m_dir = 2'b00; m_err = 1'b0; m_live = 1'b1;
      end else begin
         m_ok  = req_valid && (int'(req_floor) < NF);
         m_err = req_valid && !m_ok;
         m_set = '0;
         if (m_ok) m_set[req_floor] = 1'b1;
         m_clr = '0;
         m_go  = 1'b0;
         case (m_mode)
            M_IDLE: begin
               if (m_pend[m_floor]) begin
                  m_mode = M_DOOR; m_doorl = DC; m_clr[m_floor] = 1'b1;
               end else m_go = 1'b1;
            end
            M_TRAVEL: begin
               m_travel = m_travel - 1;
               if (m_travel == 0) begin
                  m_floor = m_up ? m_floor + 1 : m_floor - 1;
                  if (m_pend[m_floor] || m_set[m_floor]) begin
                     m_mode = M_DOOR; m_doorl = DC; m_clr[m_floor] = 1'b1;
                  end else m_travel = MC;
               end
            end
            default: begin
               if (m_ok && int'(req_floor) == m_floor) begin
                  m_doorl = DC; m_set = '0;
               end else if (!door_hold) begin
                  m_doorl = m_doorl - 1;
                  if (m_doorl == 0) m_go = 1'b1;
               end
            end
         endcase
         if (m_go) begin
            if (side_has(m_pend, m_floor, m_up)) begin
               m_mode = M_TRAVEL; m_travel = MC; m_dir = m_up ? 2'b01 : 2'b10;
            end else if (side_has(m_pend, m_floor, !m_up)) begin
               m_up = !m_up;
               m_mode = M_TRAVEL; m_travel = MC; m_dir = m_up ? 2'b01 : 2'b10;
            end else begin
               m_mode = M_IDLE; m_dir = 2'b00;
            end
         end
         m_pend = (m_pend | m_set) & ~m_clr;
      end
   end

   // compare process: every cycle, all outputs of the 8-floor instance
   always @(negedge clk) begin
      if (m_live) begin
         n_checks++;
         if (floor !== 3'(m_floor) || direction !== m_dir || door_open !== (m_mode == M_DOOR) ||
             pending !== m_pend || req_err !== m_err) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t (actual/required) floor=%0d/%0d dir=%b/%b door=%b/%b pend=%h/%h err=%b/%b",
                     $time, floor, m_floor, direction, m_dir, door_open, (m_mode == M_DOOR),
                     pending, m_pend, req_err, m_err);
         end
      end
   end

   // monitor: door episodes, stop floors, invariants
   int  mon_run = 0;
   bit  mon_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         mon_run = 0; mon_prev = 1'b0;
      end else begin
         if (door_open) begin
            if (!mon_prev) stop_q.push_back(floor);
            mon_run++;
            if (pending[floor]) pend_while_open++;
            if (phase == 2 && floor == 3'd4) floor4_open++;
         end else if (mon_prev) begin
            door_len_q.push_back(mon_run);
            mon_run = 0;
         end
         mon_prev = door_open;
         if (int'(floor6) > floor6_max) floor6_max = int'(floor6);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_req(input int f);
      req_valid = 1'b1; req_floor = 3'(f);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic send_req6(input int f);
      req6_valid = 1'b1; req6_floor = 3'(f);
      @(posedge clk); #1;
      req6_valid = 1'b0;
   endtask

   task automatic wait_door_open(input string name);
      int g;
      g = 0;
      do begin @(negedge clk); g++; end while (door_open !== 1'b1 && g < 200);
      check({name, "_open_timeout"}, 32'(door_open === 1'b1), 32'd1);
   endtask

   task automatic wait_episodes(input int n, input string name);
      int g;
      g = 0;
      while (door_len_q.size() < n && g < 300) begin @(posedge clk); g++; end
      check({name, "_episode_timeout"}, 32'(door_len_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int g;
      g = 0;
      do begin @(negedge clk); g++; end
      while (!(direction == 2'b00 && door_open == 1'b0 && pending == 8'h00) && g < 300);
      check({name, "_idle_timeout"}, 32'(g < 300), 32'd1);
      @(posedge clk); #1;
   endtask

   function automatic int len_at(input int i);
      return (door_len_q.size() > i) ? door_len_q[i] : -1;
   endfunction

   // ---------------- directed stimulus ----------------
   initial begin
      int g;
      rst = 1'b0; req_valid = 1'b0; req_floor = '0; door_hold = 1'b0;
      req6_valid = 1'b0; req6_floor = '0; hold6 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_floor", floor, 0);
      check("rst_dir", direction, 0);
      check("rst_door", door_open, 0);
      check("rst_pending", pending, 0);
      check("rst_err", req_err, 0);
      check("rst6_floor", floor6, 0);
      check("rst6_pending", pending6, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: request floor 3 from floor 0
      phase = 1;
      send_req(3);
      @(negedge clk);
      check("t1_pending_latched", pending, 8'h08);
      check("t1_idle_before_decision", direction, 2'b00);
      @(negedge clk);
      check("t1_dir_up", direction, 2'b01);
      repeat (2) @(negedge clk);
      check("t1_floor0_before_step", floor, 0);
      @(negedge clk);
      check("t1_floor1", floor, 1);
      repeat (3) @(negedge clk);
      check("t1_floor2", floor, 2);
      repeat (3) @(negedge clk);
      check("t1_floor3", floor, 3);
      check("t1_door_open_at3", door_open, 1);
      wait_episodes(1, "t1");
      check("t1_door_len", 32'(len_at(0)), 32'd4);
      @(negedge clk);
      check("t1_dir_idle_after", direction, 2'b00);
      check("t1_pending_empty", pending, 8'h00);

      // 2: SCAN ordering from floor 3 moving up with 5, 2, 1 requested
      wait_idle("t2");
      door_len_q.delete(); stop_q.delete();
      phase = 2;
      exp_q.push_back(3'd5); exp_q.push_back(3'd2); exp_q.push_back(3'd1);
      send_req(5); send_req(2); send_req(1);
      check("t2_moving_up_at3", {29'd0, floor}, 32'd3);
      wait_door_open("t2_stop5");
      check("t2_first_stop", floor, 5);
      wait_episodes(1, "t2a");
      @(negedge clk);
      check("t2_reverse_dir", direction, 2'b10);
      wait_episodes(3, "t2b");
      while (exp_q.size() > 0) begin
         logic [2:0] e;
         logic [2:0] a;
         e = exp_q.pop_front();
         a = (stop_q.size() > 0) ? stop_q.pop_front() : 3'd7;
         check("t2_stop_order", a, e);
      end
      check("t2_no_extra_stops", 32'(stop_q.size()), 32'd0);
      check("t2_never_open_at4", 32'(floor4_open), 32'd0);
      for (int i = 0; i < 3; i++) check("t2_door_len", 32'(len_at(i)), 32'd4);
      phase = 3;

      // 3: door reload at floor 2
      wait_idle("t3a");
      send_req(2);
      wait_idle("t3b");
      check("t3_at_floor2", floor, 2);
      door_len_q.delete(); stop_q.delete();
      send_req(2);
      wait_door_open("t3");
      check("t3_door_floor", floor, 2);
      @(negedge clk);
      @(negedge clk);
      req_valid = 1'b1; req_floor = 3'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_episodes(1, "t3");
      check("t3_door_len_reload", 32'(len_at(0)), 32'd7);

      // 4: door_hold for 10 cycles at floor 4
      wait_idle("t4");
      door_len_q.delete(); stop_q.delete();
      send_req(4);
      wait_door_open("t4");
      door_hold = 1'b1;
      repeat (10) @(negedge clk);
      door_hold = 1'b0;
      check("t4_still_open_at_release", door_open, 1);
      check("t4_still_at4", floor, 4);
      wait_episodes(1, "t4");
      check("t4_door_len_hold", 32'(len_at(0)), 32'd14);

      // 6: async reset mid-move with pending 0x30
      wait_idle("t6a");
      send_req(1);
      wait_idle("t6b");
      send_req(4); send_req(5);
      @(negedge clk);
      check("t6_pending_before", pending, 8'h30);
      check("t6_moving_up", direction, 2'b01);
      #2 rst = 1'b0;
      #1;
      check("t6_async_floor", floor, 0);
      check("t6_async_pending", pending, 8'h00);
      check("t6_async_door", door_open, 0);
      check("t6_async_dir", direction, 2'b00);
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_stays_idle_floor", floor, 0);
      check("t6_stays_idle_dir", direction, 2'b00);
      check("t6_stays_idle_pending", pending, 8'h00);

      // 5: six floors, out-of-range request then top floor
      send_req6(6);
      @(negedge clk);
      check("t5_err_pulse", req_err6, 1);
      check("t5_pending_unchanged", pending6, 6'h00);
      @(negedge clk);
      check("t5_err_one_cycle", req_err6, 0);
      send_req6(5);
      @(negedge clk);
      check("t5_pending_5", pending6, 6'h20);
      g = 0;
      while (door_open6 !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      check("t5_open_timeout", 32'(door_open6 === 1'b1), 32'd1);
      check("t5_stop_at5", floor6, 5);
      g = 0;
      while (door_open6 === 1'b1 && g < 200) begin @(negedge clk); g++; end
      repeat (5) @(negedge clk);
      check("t5_halted_at5", floor6, 5);
      check("t5_dir_idle", direction6, 2'b00);
      check("t5_pending_empty", pending6, 6'h00);
      check("t5_max_floor", 32'(floor6_max), 32'd5);

      check("pending_clear_while_open", 32'(pend_while_open), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
